// File: rtl/lwe_pkg.sv
// Shared definitions for the LWE encryption datapath.
//   - Default parameter set (p=64, q=1024, n=1, m=30).
//   - sum_width(): width of an untruncated sum of n entries of w bits each.
package lwe_pkg;

    localparam int PLAINTEXT_MODULUS  = 64;
    localparam int PLAINTEXT_WIDTH    = 6;
    localparam int CIPHERTEXT_MODULUS = 1024;  // must equal 2**CIPHERTEXT_WIDTH
    localparam int CIPHERTEXT_WIDTH   = 10;
    localparam int DIMENSION          = 1;
    localparam int BIG_N              = 30;

    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    // Width a non-truncating adder tree would need; the datapath truncates
    // at every adder instead, since only the low bits survive mod q.
    localparam int SUM_WIDTH = sum_width(CIPHERTEXT_WIDTH, BIG_N);

endpackage

// File: rtl/lwe_masked_sum.sv
// Combinational masked sum of public-key entries.
//   entries  in   W x N  unpacked key row, entry i = sample i
//   select   in   N      bit i=1 includes entries[i]
//   sum      out  W      sum of selected entries, mod 2**W
// Each entry is ANDed with its select bit, then reduced by a balanced
// binary adder tree. Leaves are padded with zeros up to a power of two.
module lwe_masked_sum
    import lwe_pkg::*;
#(
    parameter int W = CIPHERTEXT_WIDTH,
    parameter int N = BIG_N
) (
    input  logic [W-1:0] entries [N-1:0],
    input  logic [N-1:0] select,
    output logic [W-1:0] sum
);

    localparam int LEVELS = $clog2(N);
    localparam int LEAVES = 1 << LEVELS;

    // Level 0 holds the masked leaves; level lv holds LEAVES>>lv partial sums.
    // Each adder keeps only W bits: the carries it drops never reach the
    // low W bits of the final result.
    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
        localparam int COUNT = LEAVES >> lv;
        logic [W-1:0] val [COUNT];
        for (genvar j = 0; j < COUNT; j++) begin : g_node
            if (lv == 0) begin : g_leaf
                if (j < N) begin : g_used
                    assign val[j] = entries[j] & {W{select[j]}};
                end else begin : g_pad
                    assign val[j] = '0;
                end
            end else begin : g_add
                assign val[j] = g_lvl[lv-1].val[2*j] + g_lvl[lv-1].val[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LEVELS].val[0];

endmodule

// File: rtl/lwe_encrypt_row.sv
// One ciphertext element of an LWE (Regev-style) encryption per clock.
//   clk                  in   system clock, rising edge
//   rst_n                in   synchronous active-low reset
//   plaintext_and_noise  in   pre-encoded message term, added on row 0 only
//   publickey_row        in   unpacked key row [BIG_N-1:0], entry i = sample i
//   noise_select         in   bit i=1 includes publickey_row[i]
//   row                  in   ciphertext element index (0 carries the message)
//   ciphertext           out  registered result, 1-cycle latency
// The datapath is combinational up to the single output register so that
// latency stays at exactly one cycle.
module lwe_encrypt_row
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH  = lwe_pkg::PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_WIDTH = lwe_pkg::CIPHERTEXT_WIDTH,
    parameter int DIMENSION        = lwe_pkg::DIMENSION,
    parameter int BIG_N            = lwe_pkg::BIG_N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PLAINTEXT_WIDTH-1:0]  plaintext_and_noise,
    input  logic [CIPHERTEXT_WIDTH-1:0] publickey_row [BIG_N-1:0],
    input  logic [BIG_N-1:0]            noise_select,
    input  logic [DIMENSION:0]          row,
    output logic [CIPHERTEXT_WIDTH-1:0] ciphertext
);

    logic [CIPHERTEXT_WIDTH-1:0] masked_sum;
    logic [CIPHERTEXT_WIDTH-1:0] result;

    lwe_masked_sum #(
        .W (CIPHERTEXT_WIDTH),
        .N (BIG_N)
    ) u_masked_sum (
        .entries (publickey_row),
        .select  (noise_select),
        .sum     (masked_sum)
    );

    // Only row 0 carries the message; every other index, including values
    // above DIMENSION, is the bare sum. The add wraps mod 2**CIPHERTEXT_WIDTH.
    always_comb begin
        result = masked_sum;
        if (row == '0) begin
            result = masked_sum + CIPHERTEXT_WIDTH'(plaintext_and_noise);
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values; the reset is synchronous, so rst_n is only seen at clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ciphertext <= '0;
        end else begin
            ciphertext <= result;
        end
    end

endmodule

// File: tb/tb_lwe_encrypt_row.sv
// Self-checking bench for lwe_encrypt_row.
// Driver applies one vector per cycle at the falling edge and pushes the
// expected ciphertext into a queue; the monitor pops and compares one entry
// per rising edge (sampled 1 ns after the edge).
module tb_lwe_encrypt_row;

    localparam int PW = 6;
    localparam int CW = 10;
    localparam int M  = 30;
    localparam int Q  = 1024;

    typedef struct {
        int    value;
        string name;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [PW-1:0]  plaintext_and_noise;
    logic [CW-1:0]  publickey_row [M-1:0];
    logic [M-1:0]   noise_select;
    logic [1:0]     row;
    logic [CW-1:0]  ciphertext;

    lwe_encrypt_row dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .plaintext_and_noise (plaintext_and_noise),
        .publickey_row       (publickey_row),
        .noise_select        (noise_select),
        .row                 (row),
        .ciphertext          (ciphertext)
    );

    always #5 clk = ~clk;

    // Stimulus staged here, then copied onto the DUT pins by step().
    int          pk_m [M];
    logic [M-1:0] sel_m;
    int          msg_m;
    int          row_m;
    logic        rst_m;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: plain integer sum of selected samples, message on row 0, mod q.
    function automatic int model();
        int s = 0;
        for (int i = 0; i < M; i++) begin
            if (sel_m[i]) s += pk_m[i];
        end
        if (row_m == 0) s += msg_m;
        return s % Q;
    endfunction

    task automatic step(input int exp_val, input string name);
        exp_t e;
        @(negedge clk);
        e.value = exp_val;
        e.name  = name;
        exp_q.push_back(e);
        rst_n               = rst_m;
        plaintext_and_noise = PW'(msg_m);
        noise_select        = sel_m;
        row                 = 2'(row_m);
        for (int i = 0; i < M; i++) publickey_row[i] = CW'(pk_m[i]);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < M; i++) pk_m[i] = int'($urandom_range(Q - 1, 0));
        sel_m = M'($urandom);
        msg_m = int'($urandom_range(63, 0));
        row_m = int'($urandom_range(3, 0));
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (int'(ciphertext) != e.value) begin
                    n_bad++;
                    $display("FAIL %s: ciphertext=%0d expected=%0d", e.name, ciphertext, e.value);
                end
            end
        end
    end

    // Driver
    initial begin
        int pk_a [M];
        int pk_b [M];
        logic [M-1:0] sel_a, sel_b;
        int waited;

        pk_a = '{320, 909, 721, 278, 946, 806, 193, 593, 121, 418, 739, 642, 648, 873, 279,
                 1023, 643, 129, 666, 962, 869, 165, 698, 821, 744, 837, 466, 394, 192, 588};
        pk_b = '{576, 847, 763, 626, 294, 34, 651, 187, 819, 246, 321, 854, 24, 67, 701,
                 117, 865, 331, 350, 150, 407, 407, 318, 135, 760, 567, 70, 430, 320, 388};
        sel_a = 30'b101010001110110011100110111001;
        sel_b = 30'b100101000110100011011001101010;

        rst_n = 1'b0;
        randomize_inputs();
        rst_m = 1'b0;
        publickey_row = '{default: '0};
        noise_select = '0;
        plaintext_and_noise = '0;
        row = '0;

        // Reset held for two edges with random inputs.
        randomize_inputs(); step(0, "reset_0");
        randomize_inputs(); step(0, "reset_1");
        rst_m = 1'b1;

        // Directed vectors with hand-derived results.
        pk_m = pk_a; sel_m = sel_a; msg_m = 2; row_m = 0; step(600, "row0_sel_a");
        sel_m = sel_b; msg_m = 1;                         step(431, "row0_sel_b");
        pk_m = pk_b; sel_m = sel_a; msg_m = 2; row_m = 1; step(882, "row1_sel_a");
        sel_m = sel_b; msg_m = 1;                         step(826, "row1_sel_b");
        sel_m = '0; msg_m = 63; row_m = 0;                step(63,  "sel0_row0");
        row_m = 1;                                        step(0,   "sel0_row1");
        for (int i = 0; i < M; i++) pk_m[i] = Q - 1;
        sel_m = '1; row_m = 1;                            step(994, "all_max_row1");
        row_m = 0; msg_m = 0;                             step(994, "all_max_row0_msg0");
        msg_m = 63;                                       step(33,  "all_max_row0_msg63");
        pk_m = pk_b; sel_m = sel_b; msg_m = 5; row_m = 2; step(826, "row2_like_row1");
        row_m = 3;                                        step(826, "row3_like_row1");

        // Mid-stream reset discards the pending result.
        pk_m = pk_a; sel_m = sel_a; msg_m = 2; row_m = 0; rst_m = 1'b0;
        step(0, "midstream_reset");
        rst_m = 1'b1;
        step(600, "after_reset");

        // Back-to-back random vectors, new inputs every cycle.
        for (int k = 0; k < 1000; k++) begin
            randomize_inputs();
            case (k % 50)
                0: sel_m = '1;
                1: sel_m = '0;
                default: ;
            endcase
            step(model(), "random");
        end

        // Drain, with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
